aes_key_schedule: RTL and testbench

Sequential AES-128 key scheduler. Loads a 128-bit cipher key and iterates the existing single-round key-expansion stage (one instance, one round per clock) to produce round keys 1..10. It stores all 11 round keys (0..10) in an internal register file. It sits directly downstream of the key-expansion stage and feeds the round datapath through a random-access read port, so encrypt rounds and reverse-order decrypt rounds can both fetch keys.

---
 rtl/aes_key_schedule.sv | 160 ++++++++++++++++
 tb/tb_aes_key_schedule.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key scheduler: one key-expansion round per clock into an
// 11-entry round-key file with a combinational random-access read port.
module aes_key_schedule #(
  parameter int unsigned LENGTH  = 128,
  parameter int unsigned NROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] key_in,
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  input  logic [3:0]        rd_round,
  output logic [LENGTH-1:0] rd_key
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NROUNDS);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254 = x^2*x^4*...*x^128) plus affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [LENGTH-1:0] key_expand(input logic [LENGTH-1:0] k,
                                                   input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rcon(r), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [LENGTH-1:0]   keys_q [0:NROUNDS];
  logic                we;
  logic [3:0]          waddr;
  logic [LENGTH-1:0]   wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = key_in;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          we      = 1'b1;
          cnt_d   = 4'd1;
          state_d = EXPAND;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      EXPAND: begin
        // A corrupted counter abandons the run without touching the key file.
        if (cnt_q == 4'd0 || cnt_q > LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          we    = 1'b1;
          waddr = cnt_q;
          wdata = key_expand(keys_q[cnt_q - 4'd1], cnt_q);
          if (cnt_q == LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i <= NROUNDS; i++) keys_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      if (we) keys_q[waddr] <= wdata;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = valid_q;
  assign rd_key     = (rd_round <= LAST) ? keys_q[rd_round] : '0;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: round-key expectations go into a
// scoreboard queue at start time and are drained once the expansion completes.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, done, keys_valid;
  logic [3:0]   rd_round = '0;
  logic [127:0] rd_key;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string        tag;
    logic [3:0]   rnd;
    logic [127:0] exp;
  } exp_t;

  exp_t sb[$];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_schedule #(.LENGTH(128), .NROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rd_round(rd_round), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int r, input logic [127:0] e);
    exp_t x;
    x.tag = tag;
    x.rnd = 4'(r);
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_round = e.rnd;
      #2;
      check(e.tag, rd_key, e.exp);
      @(negedge clk);
    end
  endtask

  // Starts an expansion and watches 14 cycles; mid >= 0 re-asserts start (zero key) then.
  task automatic run_expansion(input logic [127:0] key, input int mid,
                               output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        check("valid_low_after_accept", keys_valid, 1'b0);
      end
      if (busy) nbusy++;
      if (done) ndone++;
      if (i == mid) begin
        start  = 1'b1;
        key_in = '0;
      end else if (i == mid + 1) begin
        start = 1'b0;
      end
    end
  endtask

  int nb, nd;

  initial begin
    repeat (2) @(negedge clk);
    rd_round = 4'd0;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_valid", keys_valid, 1'b0);
    check("reset_rd0", rd_key, '0);
    rd_round = 4'd11;
    #1;
    check("oob11_before", rd_key, '0);
    rd_round = 4'd15;
    #1;
    check("oob15_before", rd_key, '0);
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 key with an ignored second start during expansion
    push("fips_r0",  0,  FIPS_KEY);
    push("fips_r1",  1,  128'ha0fafe1788542cb123a339392a6c7605);
    push("fips_r2",  2,  128'hf2c295f27a96b9435935807a7359f67f);
    push("fips_r3",  3,  128'h3d80477d4716fe3e1e237e446d7a883b);
    push("fips_r4",  4,  128'hef44a541a8525b7fb671253bdb0bad00);
    push("fips_r9",  9,  128'hac7766f319fadc2128d12941575c006e);
    push("fips_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_expansion(FIPS_KEY, 3, nb, nd);
    check("fips_busy_cycles", 128'(nb), 128'd10);
    check("fips_done_pulses", 128'(nd), 128'd1);
    check("fips_valid", keys_valid, 1'b1);
    drain();
    rd_round = 4'd11;
    #1;
    check("oob11_after", rd_key, '0);
    rd_round = 4'd15;
    #1;
    check("oob15_after", rd_key, '0);

    // Restart from DONE with the all-zero key
    push("zero_r1",  1,  128'h62636363626363636263636362636363);
    push("zero_r2",  2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    push("zero_r10", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    run_expansion('0, -10, nb, nd);
    check("zero_busy_cycles", 128'(nb), 128'd10);
    check("zero_done_pulses", 128'(nd), 128'd1);
    check("zero_valid", keys_valid, 1'b1);
    drain();

    // Asynchronous reset in the middle of an expansion
    @(negedge clk);
    key_in = FIPS_KEY;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_valid", keys_valid, 1'b0);
    rd_round = 4'd0;
    #1;
    check("arst_rd0", rd_key, '0);
    rd_round = 4'd10;
    #1;
    check("arst_rd10", rd_key, '0);
    @(negedge clk);
    rst = 1'b0;

    push("post_rst_r0",  0,  FIPS_KEY);
    push("post_rst_r10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_expansion(FIPS_KEY, -10, nb, nd);
    check("post_rst_busy_cycles", 128'(nb), 128'd10);
    check("post_rst_done_pulses", 128'(nd), 128'd1);
    check("post_rst_valid", keys_valid, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
